// File: rtl/clk_meas_gate_cnt.sv
// Gated cycle counter on the clk_meas side of the frequency meter: synchronises the gate,
// counts cycles while it is high and captures the count on gate fall. Optional macro: CLK_MEAS_SAT_EN.
module clk_meas_gate_cnt #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_meas,
  input  logic             rst,
  input  logic             gate,
  input  logic             result_ack,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             result_ovf,
  output logic             result_lost,
  output logic             result_tgl
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_WIN = CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   g_s;
  logic                   g_d;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf;
  logic                   rise;
  logic                   hold;
  logic                   fall;
  logic                   capture;

  assign g_s  = sync_q[SYNC_STAGES-1];
  assign busy = g_s;

  always_ff @(posedge clk_meas or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      g_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gate};
      g_d    <= g_s;
    end
  end

  // Windows shorter than the minimum gate high time are discarded rather than captured.
  always_comb begin
    rise    = g_s & ~g_d;
    hold    = g_s & g_d;
    fall    = ~g_s & g_d;
    capture = fall & ((cnt >= MIN_WIN) | ovf);
  end

  always_ff @(posedge clk_meas or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (rise) begin
      cnt <= CNT_ONE;
      ovf <= 1'b0;
    end else if (hold) begin
      if (cnt == '1) begin
        ovf <= 1'b1;
`ifdef CLK_MEAS_SAT_EN
        cnt <= cnt;
`else
        cnt <= '0;
`endif
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_meas or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      result_ovf   <= 1'b0;
      result_lost  <= 1'b0;
      result_tgl   <= 1'b0;
    end else if (capture) begin
      result       <= cnt;
      result_ovf   <= ovf;
      result_valid <= 1'b1;
      result_tgl   <= ~result_tgl;
      // An ack landing with the capture consumes the old result, so nothing is lost.
      if (result_valid && !result_ack)
        result_lost <= 1'b1;
    end else if (result_ack && result_valid) begin
      result_valid <= 1'b0;
      result_lost  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_meas_gate_cnt.sv
// Bench for clk_meas_gate_cnt: two instances (S=2 and S=3) driven with directed and random
// gate windows, checked against a window-length based reference model.
module tb_clk_meas_gate_cnt;

  localparam int unsigned W_A = 8;
  localparam int unsigned S_A = 2;
  localparam int unsigned W_B = 10;
  localparam int unsigned S_B = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           gate_a, ack_a, gate_b, ack_b;
  logic           busy_a, valid_a, ovf_a, lost_a, tgl_a;
  logic           busy_b, valid_b, ovf_b, lost_b, tgl_b;
  logic [W_A-1:0] res_a;
  logic [W_B-1:0] res_b;
  logic [W_A+3:0] obs_a;
  logic [W_B+3:0] obs_b;

  int checks = 0;
  int errors = 0;

  longint unsigned exp_res [2];
  bit              exp_ovf [2];
  bit              exp_valid [2];
  bit              exp_lost [2];
  bit              exp_tgl [2];

  always #5 clk = ~clk;

  assign obs_a = {res_a, ovf_a, valid_a, lost_a, tgl_a};
  assign obs_b = {res_b, ovf_b, valid_b, lost_b, tgl_b};

  clk_meas_gate_cnt #(.CNT_W(W_A), .SYNC_STAGES(S_A)) dut_a (
    .clk_meas(clk), .rst(rst), .gate(gate_a), .result_ack(ack_a), .busy(busy_a),
    .result(res_a), .result_valid(valid_a), .result_ovf(ovf_a), .result_lost(lost_a),
    .result_tgl(tgl_a));

  clk_meas_gate_cnt #(.CNT_W(W_B), .SYNC_STAGES(S_B)) dut_b (
    .clk_meas(clk), .rst(rst), .gate(gate_b), .result_ack(ack_b), .busy(busy_b),
    .result(res_b), .result_valid(valid_b), .result_ovf(ovf_b), .result_lost(lost_b),
    .result_tgl(tgl_b));

  // Reference model: a window of L high cycles yields one capture (or none if too short).
  function automatic int unsigned w_of(int d);
    return (d == 0) ? W_A : W_B;
  endfunction

  function automatic int unsigned s_of(int d);
    return (d == 0) ? S_A : S_B;
  endfunction

  function automatic longint unsigned count_of(int unsigned len, int unsigned w);
    longint unsigned maxv = (64'd1 << w) - 1;
`ifdef CLK_MEAS_SAT_EN
    return (len > maxv) ? maxv : longint'(len);
`else
    return longint'(len) & maxv;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_res[d] = 0; exp_ovf[d] = 0; exp_valid[d] = 0; exp_lost[d] = 0; exp_tgl[d] = 0;
    end
  endtask

  task automatic model_ack(int d);
    if (exp_valid[d]) begin
      exp_valid[d] = 0;
      exp_lost[d]  = 0;
    end
  endtask

  task automatic model_capture(int d, int unsigned len, bit ack);
    if (len < s_of(d) + 1) begin
      if (ack) model_ack(d);
      return;
    end
    if (exp_valid[d] && !ack) exp_lost[d] = 1;
    exp_valid[d] = 1;
    exp_tgl[d]   = ~exp_tgl[d];
    exp_res[d]   = count_of(len, w_of(d));
    exp_ovf[d]   = (longint'(len) >= (64'd1 << w_of(d)));
  endtask

  function automatic logic [W_A+3:0] exp_a();
    return {W_A'(exp_res[0]), exp_ovf[0], exp_valid[0], exp_lost[0], exp_tgl[0]};
  endfunction

  function automatic logic [W_B+3:0] exp_b();
    return {W_B'(exp_res[1]), exp_ovf[1], exp_valid[1], exp_lost[1], exp_tgl[1]};
  endfunction

  // Window of len high cycles on instance A; optional ack in the capture cycle.
  task automatic win_a(int unsigned len, bit ack_cap);
    gate_a = 1'b1;
    repeat (len) @(negedge clk);
    gate_a = 1'b0;
    repeat (S_A) @(negedge clk);
    if (ack_cap) ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    model_capture(0, len, ack_cap);
  endtask

  task automatic win_b(int unsigned len);
    gate_b = 1'b1;
    repeat (len) @(negedge clk);
    gate_b = 1'b0;
    repeat (S_B + 1) @(negedge clk);
    model_capture(1, len, 1'b0);
  endtask

  task automatic ack_pulse_a();
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    model_ack(0);
  endtask

  task automatic test_reset();
    model_reset();
    checks++;
    if ({obs_a, busy_a} !== '0) begin
      errors++; $display("FAIL reset_a: got %h expected 0", {obs_a, busy_a});
    end
    checks++;
    if ({obs_b, busy_b} !== '0) begin
      errors++; $display("FAIL reset_b: got %h expected 0", {obs_b, busy_b});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    gate_a = 1'b1;
    repeat (S_A) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL busy_rise: got %b expected 1", busy_a);
    end
    repeat (100 - S_A) @(negedge clk);
    gate_a = 1'b0;
    repeat (S_A) @(negedge clk);
    checks++;
    if (valid_a !== 1'b0) begin
      errors++; $display("FAIL valid_early: got %b expected 0", valid_a);
    end
    @(negedge clk);
    model_capture(0, 100, 1'b0);
    checks++;
    if (obs_a !== exp_a() || res_a !== 8'd100 || tgl_a !== 1'b1) begin
      errors++; $display("FAIL basic_100: got %h expected %h", obs_a, exp_a());
    end
    ack_pulse_a();
  endtask

  task automatic test_overflow();
    win_a(300, 1'b0);
    checks++;
    if (obs_a !== exp_a() || ovf_a !== 1'b1) begin
      errors++; $display("FAIL overflow_300: got %h expected %h", obs_a, exp_a());
    end
    ack_pulse_a();
  endtask

  task automatic test_lost();
    win_a(10, 1'b0);
    win_a(20, 1'b0);
    checks++;
    if (obs_a !== exp_a() || res_a !== 8'd20 || lost_a !== 1'b1 || tgl_a !== 1'b0) begin
      errors++; $display("FAIL lost: got %h expected %h", obs_a, exp_a());
    end
    ack_pulse_a();
    checks++;
    if (obs_a !== exp_a() || valid_a !== 1'b0 || lost_a !== 1'b0) begin
      errors++; $display("FAIL ack_clear: got %h expected %h", obs_a, exp_a());
    end
  endtask

  task automatic test_ack_coincident();
    win_a(10, 1'b0);
    win_a(15, 1'b1);
    checks++;
    if (obs_a !== exp_a() || valid_a !== 1'b1 || lost_a !== 1'b0 || res_a !== 8'd15) begin
      errors++; $display("FAIL ack_coincident: got %h expected %h", obs_a, exp_a());
    end
    ack_pulse_a();
    ack_pulse_a();
    checks++;
    if (obs_a !== exp_a()) begin
      errors++; $display("FAIL ack_idle: got %h expected %h", obs_a, exp_a());
    end
  endtask

  task automatic test_back_to_back();
    int unsigned l1 = $urandom_range(5, 40);
    int unsigned l2 = $urandom_range(5, 40);
    gate_a = 1'b1;
    repeat (l1) @(negedge clk);
    gate_a = 1'b0;
    @(negedge clk);
    gate_a = 1'b1;
    repeat (S_A) @(negedge clk);
    model_capture(0, l1, 1'b0);
    checks++;
    if (obs_a !== exp_a() || busy_a !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got %h busy %b expected %h busy 1", obs_a, busy_a, exp_a());
    end
    repeat (l2 - S_A) @(negedge clk);
    gate_a = 1'b0;
    repeat (S_A + 1) @(negedge clk);
    model_capture(0, l2, 1'b0);
    checks++;
    if (obs_a !== exp_a()) begin
      errors++; $display("FAIL b2b_second: got %h expected %h (l1 %0d l2 %0d)", obs_a, exp_a(), l1, l2);
    end
    ack_pulse_a();
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int unsigned len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 300);
      bit ack_cap = 1'($urandom_range(0, 1));
      win_a(len, ack_cap);
      checks++;
      if (obs_a !== exp_a()) begin
        errors++; $display("FAIL random_%0d: got %h expected %h (len %0d)", i, obs_a, exp_a(), len);
      end
      if ($urandom_range(0, 1) == 1) ack_pulse_a();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    win_a(12, 1'b0);
    gate_a = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    gate_a = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({obs_a, busy_a} !== '0) begin
      errors++; $display("FAIL reset_mid_during: got %h expected 0", {obs_a, busy_a});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({obs_a, busy_a} !== '0) begin
      errors++; $display("FAIL reset_mid_after: got %h expected 0", {obs_a, busy_a});
    end
    win_a(5, 1'b0);
    checks++;
    if (obs_a !== exp_a() || res_a !== 8'd5 || tgl_a !== 1'b1) begin
      errors++; $display("FAIL reset_mid_next: got %h expected %h", obs_a, exp_a());
    end
  endtask

  task automatic test_short_pulse();
    win_b(2);
    checks++;
    if (obs_b !== exp_b() || valid_b !== 1'b0) begin
      errors++; $display("FAIL short_pulse: got %h expected %h", obs_b, exp_b());
    end
    win_b(4);
    checks++;
    if (obs_b !== exp_b() || res_b !== 10'd4 || valid_b !== 1'b1) begin
      errors++; $display("FAIL pulse_4: got %h expected %h", obs_b, exp_b());
    end
    win_b($urandom_range(1, 1100));
    checks++;
    if (obs_b !== exp_b()) begin
      errors++; $display("FAIL random_b: got %h expected %h", obs_b, exp_b());
    end
  endtask

  initial begin
    rst = 1'b1; gate_a = 1'b0; ack_a = 1'b0; gate_b = 1'b0; ack_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_lost();
    test_ack_coincident();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_short_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_meas_gate_cnt.md
# clk_meas_gate_cnt

Parametrised gated cycle counter for the measured-clock side of the frequency meter. It synchronises a gate level driven from the reference-clock domain and counts `clk_meas` cycles while the gate is high. On gate fall it captures the count into a held result register with valid/ack handshake, overflow and lost-result flags, and a capture toggle for cross-domain readout. It succeeds the fixed 32-bit single-shot counter, adding configurable width and synchroniser depth, back-to-back windows and result buffering.

## Interface
- `CNT_W`, 32, counter and result width (4..48)
- `SYNC_STAGES`, 2, gate synchroniser depth (2..4)
- `clk_meas`  in  1  measured clock, the only clock of this block
- `rst`  in  1  reset: asynchronous, active-high
- `gate`  in  1  measurement window level; asynchronous, must come from a register in the reference domain
- `result_ack`  in  1  single-cycle acknowledge, `clk_meas` domain
- `busy`  out  1  synchronised gate (window active)
- `result`  out  CNT_W  last captured count
- `result_valid`  out  1  `result` holds an unacknowledged capture
- `result_ovf`  out  1  counter overflowed during the captured window
- `result_lost`  out  1  a capture overwrote an unacknowledged one
- `result_tgl`  out  1  toggles on every capture, for the toggle-sync crossing

## Operation
- Synchroniser: chain of SYNC_STAGES flops, reset 0; last stage `g_s`, plus one extra delay flop `g_d`.
- rise = `g_s & ~g_d`: `cnt <= 1`, `ovf <= 0`.
- hold = `g_s & g_d`: `cnt <= cnt + 1`.
- `cnt` = number of cycles `g_s` was high.
- Increment at `cnt` = all-ones:
  - `ovf <= 1` (sticky for the window).
  - Wrap/hold behaviour is set by the macro (see Configuration).
- fall = `~g_s & g_d` (capture):
  - `result <= cnt`, `result_ovf <= ovf`.
  - `result_valid <= 1`, `result_tgl <= ~result_tgl`.
- Capture while `result_valid=1` and `result_ack=0`: new data overwrites; `result_lost <= 1`.
- `result_ack` with no capture in the same cycle: `result_valid <= 0`, `result_lost <= 0`.
- `result_ack` coincident with a capture: new data loaded, `result_valid` stays 1, `result_lost` unchanged (not set).
- `result_ack` while `result_valid=0`: ignored.
- Back-to-back windows: a rise in the cycle after a capture starts a new count. The held result is unaffected until the next fall.
- `cnt` is internal. Its value outside a window is don't-care.
- Reset, including mid-window:
  - All flops cleared; every output reads 0.
  - The partial window is discarded; no capture occurs.
  - A gate still high after reset release is seen as a fresh rise once synchronised.

## Timing
- `gate` rise → `busy` high after SYNC_STAGES `clk_meas` edges.
- Let cycle k be the first cycle with `g_s=0, g_d=1`:
  - Capture is registered at the end of cycle k.
  - `result`, `result_valid` and `result_tgl` change in cycle k+1.
- Capture latency from `gate` fall: SYNC_STAGES+1 edges.
- Accuracy:
  - Windows are measured ±1 cycle per edge due to synchroniser phase.
  - The minimum gate high/low time is SYNC_STAGES+1 `clk_meas` cycles; shorter pulses may be missed or merged.
- `result` is stable from cycle k+1 until the next capture. A consumer in another domain samples it 2+ cycles after seeing `result_tgl` change.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `CLK_MEAS_SAT_EN`:
  - Defined: the counter saturates at all-ones (2^CNT_W−1) and holds for the rest of the window; `result_ovf` = 1.
  - Undefined: the counter wraps modulo 2^CNT_W; `result_ovf` = 1.
- The overflow flag behaves identically in both builds.

## Test plan
- CNT_W=8, SYNC_STAGES=2, `gate` high for 100 cycles, synchronous to `clk_meas`:
  - `result`=100, `result_ovf`=0.
  - `result_valid` rises 3 edges after `gate` falls; `result_tgl` 0→1.
- CNT_W=8, `gate` high for 300 cycles:
  - Without the macro: `result`=44, `result_ovf`=1.
  - With `CLK_MEAS_SAT_EN`: `result`=255, `result_ovf`=1.
- Windows of 10 then 20 cycles, no ack:
  - `result`=20, `result_lost`=1, `result_tgl` back at 0.
  - One-cycle `result_ack`: `result_valid`=0, `result_lost`=0.
- `result_ack` pulsed in the same cycle the second capture is registered:
  - `result_valid` remains 1, `result_lost`=0, `result` = new count.
- `rst` pulsed 50 cycles into a window; `gate` dropped, then a 5-cycle window follows:
  - Outputs all 0 during/after reset; no capture from the aborted window.
  - Next capture `result`=5.
- SYNC_STAGES=3, `gate` 2-cycle high pulse: no capture, `result_valid`=0; a 4-cycle pulse gives `result`=4.
